// File: rtl/adex_pkg.sv
// rtl/adex_pkg.sv - shared types and constants for the AdEx spike event transmitter
package adex_pkg;

    localparam int TS_W     = 15;
    localparam int REC_W    = 16;
    localparam int DROP_BIT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } tx_state_t;

endpackage

// File: rtl/adex_sync_fifo.sv
// rtl/adex_sync_fifo.sv - synchronous FIFO with wrap-bit pointers and occupancy count
module adex_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    // Pointers share low bits when full or empty; the extra MSB tells them apart.
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointer advance; overfull writes and empty reads are silently ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adex_spike_event_tx.sv
// rtl/adex_spike_event_tx.sv - timestamps spikes, buffers records, streams them as byte pairs
module adex_spike_event_tx
    import adex_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     tick_en,
    input  logic                     spike_in,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic [7:0]               drop_count
);

    logic [TS_W-1:0]  ts_q;
    logic             drop_pending_q;
    logic [7:0]       drop_count_q;
    tx_state_t        state_q;
    logic [7:0]       rec_lo_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;

    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec;
    logic             fifo_empty;
    logic             spike_seen;
    logic             push;
    logic             drop;
    logic             pop;

    assign spike_seen = enable && spike_in;
    assign push       = spike_seen && !fifo_full;
    assign drop       = spike_seen && fifo_full;
    assign pop        = !fifo_empty &&
                        ((state_q == IDLE) || ((state_q == SEND_LO) && out_ready));

    // Record layout: drop flag on top, pre-increment timestamp below.
    always_comb begin
        wr_rec                = '0;
        wr_rec[DROP_BIT]      = drop_pending_q;
        wr_rec[TS_W-1:0]      = ts_q;
    end

    adex_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (wr_rec),
        .rd_en_i   (pop),
        .rd_data_o (rd_rec),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Timestep counter; wraps naturally at the top of its 15-bit range.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else if (enable && tick_en) begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Overflow tracking: flag the next stored record and count lost spikes.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pending_q <= 1'b0;
            drop_count_q   <= '0;
        end else if (drop) begin
            drop_pending_q <= 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end else if (push) begin
            drop_pending_q <= 1'b0;
        end
    end

    // Serializer: high byte then low byte, chaining the next record with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rec_lo_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        rec_lo_q    <= rd_rec[7:0];
                        out_data_q  <= rd_rec[15:8];
                        out_valid_q <= 1'b1;
                        state_q     <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (out_ready) begin
                        out_data_q <= rec_lo_q;
                        state_q    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (out_ready) begin
                        if (pop) begin
                            rec_lo_q   <= rd_rec[7:0];
                            out_data_q <= rd_rec[15:8];
                            state_q    <= SEND_HI;
                        end else begin
                            out_data_q  <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_adex_spike_event_tx.sv
// tb/tb_adex_spike_event_tx.sv - directed self-checking bench for adex_spike_event_tx
module tb_adex_spike_event_tx;

    localparam int DEPTH = 8;

    logic                    clk;
    logic                    rst;
    logic                    enable;
    logic                    tick_en;
    logic                    spike_in;
    logic [7:0]              out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_full;
    logic [7:0]              drop_count;

    int n_checks;
    int n_errors;

    adex_spike_event_tx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick_en    (tick_en),
        .spike_in   (spike_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_en = 1'b1;
        repeat (n) step();
        tick_en = 1'b0;
    endtask

    task automatic spike();
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
    endtask

    // Accept one byte with out_ready high; bounded wait for out_valid.
    task automatic expect_byte(input string tag, input logic [7:0] exp);
        bit got;
        got = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                chk(tag, 32'(out_data), 32'(exp));
                step();
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        enable    = 1'b1;
        tick_en   = 1'b0;
        spike_in  = 1'b0;
        out_ready = 1'b0;
        #2;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_full",  32'(fifo_full), 0);
        chk("rst_drop",  32'(drop_count), 0);

        // Single spike at ts=5, latency and return to idle
        ticks(5);
        out_ready = 1'b1;
        spike();
        chk("s1_count_k", 32'(fifo_count), 1);
        chk("s1_valid_k", 32'(out_valid), 0);
        step();
        chk("s1_valid_k1", 32'(out_valid), 1);
        chk("s1_hi",       32'(out_data), 32'h00);
        chk("s1_count_k1", 32'(fifo_count), 0);
        step();
        chk("s1_valid_lo", 32'(out_valid), 1);
        chk("s1_lo",       32'(out_data), 32'h05);
        step();
        chk("s1_idle", 32'(out_valid), 0);
        chk("s1_count_end", 32'(fifo_count), 0);

        // Backpressure on ts=0x1234
        do_reset();
        ticks(32'h1234);
        out_ready = 1'b0;
        spike();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_hold", 32'(out_valid), 1);
            chk("bp_data_hold",  32'(out_data), 32'h12);
            step();
        end
        expect_byte("bp_hi", 8'h12);
        expect_byte("bp_lo", 8'h34);
        chk("bp_idle", 32'(out_valid), 0);

        // Overflow: one record sits in the serializer, DEPTH in the FIFO, three dropped
        do_reset();
        out_ready = 1'b0;
        tick_en   = 1'b1;
        spike_in  = 1'b1;
        repeat (DEPTH + 4) step();
        tick_en   = 1'b0;
        spike_in  = 1'b0;
        chk("ov_full",  32'(fifo_full), 1);
        chk("ov_count", 32'(fifo_count), DEPTH);
        chk("ov_drop",  32'(drop_count), 3);
        for (int i = 0; i <= DEPTH; i++) begin
            expect_byte("ov_rec_hi", 8'h00);
            expect_byte("ov_rec_lo", 8'(i));
        end
        chk("ov_drained", 32'(fifo_count), 0);
        ticks(32'h40 - (DEPTH + 4));
        spike();
        expect_byte("ov_flag_hi", 8'h80);
        expect_byte("ov_flag_lo", 8'h40);
        chk("ov_drop_kept", 32'(drop_count), 3);

        // Same-cycle tick and spike
        do_reset();
        ticks(7);
        tick_en  = 1'b1;
        spike();
        tick_en  = 1'b0;
        spike();
        expect_byte("tk_a_hi", 8'h00);
        expect_byte("tk_a_lo", 8'h07);
        expect_byte("tk_b_hi", 8'h00);
        expect_byte("tk_b_lo", 8'h08);

        // Wrap at 0x7FFF, then enable low freezes capture and timestamp but not drain
        do_reset();
        out_ready = 1'b0;
        ticks(32'h7FFF);
        ticks(1);
        spike();
        spike();
        chk("en_count_pre", 32'(fifo_count), 1);
        enable   = 1'b0;
        spike_in = 1'b1;
        tick_en  = 1'b1;
        repeat (4) step();
        chk("en_count_hold", 32'(fifo_count), 1);
        chk("en_drop_hold",  32'(drop_count), 0);
        expect_byte("wr_a_hi", 8'h00);
        expect_byte("wr_a_lo", 8'h00);
        expect_byte("wr_b_hi", 8'h00);
        expect_byte("wr_b_lo", 8'h00);
        spike_in = 1'b0;
        tick_en  = 1'b0;
        step();
        chk("en_drained", 32'(fifo_count), 0);
        enable = 1'b1;
        spike();
        expect_byte("en_ts_hi", 8'h00);
        expect_byte("en_ts_lo", 8'h00);

        // Reset during SEND_LO with records queued
        do_reset();
        ticks(5);
        out_ready = 1'b0;
        tick_en   = 1'b1;
        repeat (4) spike();
        tick_en   = 1'b0;
        chk("mr_count_pre", 32'(fifo_count), 3);
        out_ready = 1'b1;
        step();
        chk("mr_in_lo", 32'(out_data), 32'h05);
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_count", 32'(fifo_count), 0);
        chk("mr_drop",  32'(drop_count), 0);
        step();
        chk("mr_no_replay", 32'(out_valid), 0);
        spike();
        expect_byte("mr_ts_hi", 8'h00);
        expect_byte("mr_ts_lo", 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
